// File: rtl/comp_pkg.sv
// Shared types for the serial magnitude comparator.
//   state_t : FSM states (IDLE, CMP, DONE)
//   res_t   : per-chunk compare result (EQ, GT, LT)
//   to_res  : folds one-hot eq/gt/lt flags into a res_t
package comp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CMP,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        EQ,
        GT,
        LT
    } res_t;

    function automatic res_t to_res(input logic eq, input logic gt, input logic lt);
        res_t r;
        r = EQ;
        if (eq)      r = EQ;
        else if (gt) r = GT;
        else if (lt) r = LT;
        return r;
    endfunction

endpackage

// File: rtl/chunk_cmp.sv
// Combinational unsigned compare of two CHUNK-bit values.
//   x, y       : operand chunks
//   eq, gt, lt : one-hot result (x==y, x>y, x<y)
module chunk_cmp #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    always_comb begin
        eq = (x == y);
        gt = (x > y);
        lt = (x < y);
    end

endmodule

// File: rtl/ser_mag_comp.sv
// Serial magnitude comparator: compares a and b CHUNK bits per cycle,
// MSB chunk first, exiting early on the first differing chunk.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid, in_ready  : operand handshake (accepted only in IDLE)
//   a, b, sgn           : operands; sgn=1 selects two's-complement compare
//   out_valid, out_ready: result handshake (result held in DONE)
//   aeqb, agtb, altb    : one-hot result, all zero while out_valid=0
//   ncmp                : number of chunks examined for the current result
module ser_mag_comp
    import comp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [WIDTH-1:0]                 a,
    input  logic [WIDTH-1:0]                 b,
    input  logic                             sgn,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             aeqb,
    output logic                             agtb,
    output logic                             altb,
    output logic [$clog2(WIDTH/CHUNK):0]     ncmp
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int NCW    = $clog2(NCHUNK) + 1;

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  a_r, b_r;
    logic              sgn_r;
    logic [IDXW-1:0]   idx;
    logic [CHUNK-1:0]  ca, cb;
    logic              c_eq, c_gt, c_lt;
    res_t              res;

    // Signed compare: flipping the sign bit of the MSB chunk maps two's
    // complement ordering onto unsigned ordering; lower chunks are unsigned.
    always_comb begin
        ca = a_r[CHUNK*idx +: CHUNK];
        cb = b_r[CHUNK*idx +: CHUNK];
        if (sgn_r && (idx == IDXW'(NCHUNK-1))) begin
            ca[CHUNK-1] = ~ca[CHUNK-1];
            cb[CHUNK-1] = ~cb[CHUNK-1];
        end
    end

    chunk_cmp #(.CHUNK(CHUNK)) u_chunk_cmp (
        .x  (ca),
        .y  (cb),
        .eq (c_eq),
        .gt (c_gt),
        .lt (c_lt)
    );

    assign res = to_res(c_eq, c_gt, c_lt);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = CMP;
            CMP:     if (res != EQ || idx == '0) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_r   <= '0;
            b_r   <= '0;
            sgn_r <= 1'b0;
            idx   <= '0;
            ncmp  <= '0;
            aeqb  <= 1'b0;
            agtb  <= 1'b0;
            altb  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= a;
                        b_r   <= b;
                        sgn_r <= sgn;
                        idx   <= IDXW'(NCHUNK-1);
                        ncmp  <= '0;
                    end
                end
                CMP: begin
                    ncmp <= ncmp + NCW'(1);
                    case (res)
                        GT:      agtb <= 1'b1;
                        LT:      altb <= 1'b1;
                        default: begin
                            if (idx == '0) aeqb <= 1'b1;
                            else           idx  <= idx - IDXW'(1);
                        end
                    endcase
                end
                DONE: begin
                    if (out_ready) begin
                        aeqb <= 1'b0;
                        agtb <= 1'b0;
                        altb <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

endmodule

// File: tb/tb_ser_mag_comp.sv
// Directed self-checking bench for ser_mag_comp (WIDTH=16, CHUNK=4).
module tb_ser_mag_comp;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a, b;
    logic        sgn;
    logic        out_valid;
    logic        out_ready;
    logic        aeqb, agtb, altb;
    logic [2:0]  ncmp;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    ser_mag_comp #(.WIDTH(16), .CHUNK(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sgn       (sgn),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .aeqb      (aeqb),
        .agtb      (agtb),
        .altb      (altb),
        .ncmp      (ncmp)
    );

    // Presents one operand pair, scrambles the inputs after the accept edge,
    // and returns the number of edges from accept (inclusive) to out_valid.
    task automatic do_cmp(input logic [15:0] va, input logic [15:0] vb,
                          input logic vs, output int lat);
        in_valid = 1'b1;
        a = va; b = vb; sgn = vs;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); sgn = ~vs;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; sgn = 1'b0;
        repeat (3) @(posedge clk);
        #1; rst = 1'b0;
        total++;
        if ({in_ready, out_valid, aeqb, agtb, altb, ncmp} !== 8'b1_0_000_000) begin
            $display("FAIL reset_state got in_ready=%b out_valid=%b flags=%b%b%b ncmp=%0d want 1 0 000 0",
                     in_ready, out_valid, aeqb, agtb, altb, ncmp);
        end else passed++;
    endtask

    task automatic run_table(input string name, input logic [15:0] ta[4], input logic [15:0] tb_[4],
                             input logic ts[4], input logic [2:0] tf[4], input logic [2:0] tn[4]);
        int lat;
        for (int i = 0; i < 4; i++) begin
            do_cmp(ta[i], tb_[i], ts[i], lat);
            total++;
            if ({aeqb, agtb, altb} !== tf[i] || ncmp !== tn[i] || lat !== int'(tn[i]) + 1) begin
                $display("FAIL %s[%0d] a=%h b=%h s=%b got flags=%b%b%b ncmp=%0d lat=%0d want %b %0d %0d",
                         name, i, ta[i], tb_[i], ts[i], aeqb, agtb, altb, ncmp, lat,
                         tf[i], tn[i], int'(tn[i]) + 1);
            end else passed++;
            release_result();
            total++;
            if ({out_valid, in_ready, aeqb, agtb, altb} !== 5'b01_000) begin
                $display("FAIL %s_release[%0d] got out_valid=%b in_ready=%b flags=%b%b%b want 0 1 000",
                         name, i, out_valid, in_ready, aeqb, agtb, altb);
            end else passed++;
        end
    endtask

    // flags are {aeqb, agtb, altb}
    task automatic test_unsigned();
        logic [15:0] ta[4] = '{16'h1234, 16'h8000, 16'h1235, 16'h0100};
        logic [15:0] tb_[4] = '{16'h1234, 16'h0001, 16'h1234, 16'h0200};
        logic        ts[4] = '{1'b0, 1'b0, 1'b0, 1'b0};
        logic [2:0]  tf[4] = '{3'b100, 3'b010, 3'b010, 3'b001};
        logic [2:0]  tn[4] = '{3'd4, 3'd1, 3'd4, 3'd2};
        run_table("unsigned", ta, tb_, ts, tf, tn);
    endtask

    task automatic test_signed();
        logic [15:0] ta[4] = '{16'h8000, 16'hFFFF, 16'h7000, 16'hFFFF};
        logic [15:0] tb_[4] = '{16'h0001, 16'hFFFE, 16'h9000, 16'hFFFF};
        logic        ts[4] = '{1'b1, 1'b1, 1'b1, 1'b1};
        logic [2:0]  tf[4] = '{3'b001, 3'b010, 3'b010, 3'b100};
        logic [2:0]  tn[4] = '{3'd1, 3'd4, 3'd1, 3'd4};
        run_table("signed", ta, tb_, ts, tf, tn);
    endtask

    task automatic test_backpressure();
        int lat;
        do_cmp(16'h0100, 16'h0200, 1'b0, lat);   // lt after 2 chunks
        in_valid = 1'b1; a = 16'h4000; b = 16'h3FFF; sgn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({out_valid, in_ready, aeqb, agtb, altb, ncmp} !== 8'b10_001_010) begin
                $display("FAIL hold[%0d] got out_valid=%b in_ready=%b flags=%b%b%b ncmp=%0d want 1 0 001 2",
                         i, out_valid, in_ready, aeqb, agtb, altb, ncmp);
            end else passed++;
            @(posedge clk); #1;
        end
        release_result();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            $display("FAIL hold_idle got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end else passed++;
        // in_valid still high: this edge accepts 0x4000 vs 0x3FFF
        @(posedge clk); #1;
        in_valid = 1'b0; a = 16'h0000; b = 16'hFFFF;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        total++;
        if ({aeqb, agtb, altb} !== 3'b010 || ncmp !== 3'd1 || lat !== 2) begin
            $display("FAIL next_after_hold got flags=%b%b%b ncmp=%0d lat=%0d want 010 1 2",
                     aeqb, agtb, altb, ncmp, lat);
        end else passed++;
        release_result();
    endtask

    task automatic test_reset_mid();
        int lat;
        int seen = 0;
        in_valid = 1'b1; a = 16'h1234; b = 16'h1234; sgn = 1'b0;
        @(posedge clk); #1;            // accept; first CMP cycle
        in_valid = 1'b0;
        @(posedge clk); #1;            // second CMP cycle
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++;
        if ({in_ready, out_valid, aeqb, agtb, altb, ncmp} !== 8'b1_0_000_000) begin
            $display("FAIL rst_mid got in_ready=%b out_valid=%b flags=%b%b%b ncmp=%0d want 1 0 000 0",
                     in_ready, out_valid, aeqb, agtb, altb, ncmp);
        end else passed++;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        total++;
        if (seen !== 0) begin
            $display("FAIL rst_mid_no_valid got %0d out_valid cycles want 0", seen);
        end else passed++;
        do_cmp(16'h1234, 16'h1230, 1'b0, lat);
        total++;
        if ({aeqb, agtb, altb} !== 3'b010 || ncmp !== 3'd4 || lat !== 5) begin
            $display("FAIL rst_mid_fresh got flags=%b%b%b ncmp=%0d lat=%0d want 010 4 5",
                     aeqb, agtb, altb, ncmp, lat);
        end else passed++;
        release_result();
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_backpressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
